// File: rtl/plate_scheduler.sv
// Platform slot scheduler: scrolls and respawns platform slots once per frame,
// checks doodle landings, and arbitrates per-scanline platform draw requests.
module plate_scheduler #(
    parameter int          N_PLATES  = 4,
    parameter int          PLATE_W   = 64,
    parameter int          PLATE_H   = 8,
    parameter int          DOODLE_W  = 64,
    parameter int          DOODLE_H  = 64,
    parameter int          V_RES     = 480,
    parameter int          SPACING   = 120,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        i_clk_25,
    input  logic        i_rst_n,
    input  logic        i_frame,
    input  logic        i_line,
    input  logic [15:0] i_sy,
    input  logic [5:0]  i_scroll,
    input  logic [15:0] i_doodle_x,
    input  logic [15:0] i_doodle_y,
    input  logic        i_doodle_falling,
    output logic        o_plate_start,
    output logic [15:0] o_platex,
    output logic        o_bounce,
    output logic        o_busy
);

    localparam int K_W = (N_PLATES > 1) ? $clog2(N_PLATES) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_PLATES - 1);
    localparam logic signed [16:0] V_RES_S = 17'(V_RES);
    localparam logic signed [16:0] PLATE_W_S = 17'(PLATE_W);
    localparam logic signed [16:0] PLATE_H_S = 17'(PLATE_H);
    localparam logic signed [16:0] DOODLE_W_S = 17'(DOODLE_W);
    localparam logic signed [16:0] DOODLE_H_S = 17'(DOODLE_H);

    typedef enum logic [1:0] {IDLE, UPDATE, COLLIDE, DONE} state_t;

    state_t state, state_next;

    logic [K_W-1:0]     k;
    logic signed [15:0] x [N_PLATES];
    logic signed [15:0] y [N_PLATES];
    logic [15:0]        lfsr;
    logic [5:0]         scroll;
    logic signed [15:0] dx, dy;
    logic               falling;
    logic               flag;

    logic signed [16:0] yn, y_wrap, bottom;
    logic               respawn, hit;
    logic               match;
    logic signed [15:0] win_x;

    function automatic logic signed [16:0] sext(input logic signed [15:0] v);
        return {v[15], v};
    endfunction

    // Fibonacci taps 16,14,13,11 (bits 15,13,12,10), shifting left.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always_ff @(posedge i_clk_25) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_frame) state_next = UPDATE;
            UPDATE:  if (k == K_LAST) state_next = COLLIDE;
            COLLIDE: if (k == K_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        yn      = sext(y[k]) + signed'({11'b0, scroll});
        y_wrap  = yn - V_RES_S;
        respawn = (yn >= V_RES_S);
        bottom  = sext(dy) + DOODLE_H_S;
        hit     = falling
                  && (sext(y[k]) <= bottom)
                  && (bottom < sext(y[k]) + PLATE_H_S)
                  && (sext(dx) + DOODLE_W_S > sext(x[k]))
                  && (sext(dx) < sext(x[k]) + PLATE_W_S);
    end

    // Descending scan so the lowest-index matching slot wins.
    always_comb begin
        match = 1'b0;
        win_x = '0;
        for (int i = N_PLATES - 1; i >= 0; i--) begin
            if (y[i] == $signed(i_sy)) begin
                match = 1'b1;
                win_x = x[i];
            end
        end
    end

    always_ff @(posedge i_clk_25) begin
        if (!i_rst_n) begin
            k             <= '0;
            lfsr          <= LFSR_SEED;
            scroll        <= '0;
            dx            <= '0;
            dy            <= '0;
            falling       <= 1'b0;
            flag          <= 1'b0;
            o_plate_start <= 1'b0;
            o_platex      <= '0;
            for (int i = 0; i < N_PLATES; i++) begin
                x[i] <= 16'(64 + 128 * i);
                y[i] <= 16'(V_RES - SPACING * (i + 1));
            end
        end else begin
            o_plate_start <= i_line && match;
            if (i_line && match) o_platex <= win_x;

            case (state)
                IDLE: begin
                    if (i_frame) begin
                        scroll  <= i_scroll;
                        dx      <= i_doodle_x;
                        dy      <= i_doodle_y;
                        falling <= i_doodle_falling;
                        flag    <= 1'b0;
                        k       <= '0;
                    end
                end
                UPDATE: begin
                    if (respawn) begin
                        y[k] <= y_wrap[15:0];
                        x[k] <= {7'b0, lfsr[8:0]};
                        lfsr <= lfsr_step(lfsr);
                    end else begin
                        y[k] <= yn[15:0];
                    end
                    k <= (k == K_LAST) ? '0 : k + K_W'(1);
                end
                COLLIDE: begin
                    flag <= flag | hit;
                    k    <= (k == K_LAST) ? '0 : k + K_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_busy   = (state != IDLE);
    assign o_bounce = (state == DONE) && flag;

endmodule

// File: tb/tb_plate_scheduler.sv
// Directed bench for plate_scheduler: table-driven scanline queries plus
// hand-written frame sequences for scroll, respawn, bounce and reset corners.
module tb_plate_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame, line;
    logic [15:0] sy;
    logic [5:0]  scroll;
    logic [15:0] doodle_x, doodle_y;
    logic        falling;
    logic        plate_start;
    logic [15:0] platex;
    logic        bounce, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    plate_scheduler dut (
        .i_clk_25         (clk),
        .i_rst_n          (rst_n),
        .i_frame          (frame),
        .i_line           (line),
        .i_sy             (sy),
        .i_scroll         (scroll),
        .i_doodle_x       (doodle_x),
        .i_doodle_y       (doodle_y),
        .i_doodle_falling (falling),
        .o_plate_start    (plate_start),
        .o_platex         (platex),
        .o_bounce         (bounce),
        .o_busy           (busy)
    );

    typedef struct {
        logic [15:0] sy;
        logic        start;
        logic [15:0] px;
    } line_vec_t;

    line_vec_t v_reset [5];
    line_vec_t v_s10   [5];
    line_vec_t v_resp  [2];
    line_vec_t v_final [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic line_query(input line_vec_t v, input string tag);
        sy   = v.sy;
        line = 1'b1;
        tick();
        line = 1'b0;
        check({tag, " start"}, 32'(plate_start), 32'(v.start));
        check({tag, " platex"}, 32'(platex), 32'(v.px));
        tick();
        check({tag, " start drop"}, 32'(plate_start), 32'd0);
    endtask

    task automatic run_frame(input logic [5:0] scr, input logic [15:0] dxv, input logic [15:0] dyv,
                             input logic fall, input int frame_again_at, input int rst_at,
                             output int busy_len, output int bounce_cnt, output int bounce_at);
        busy_len   = 0;
        bounce_cnt = 0;
        bounce_at  = 0;
        scroll   = scr;
        doodle_x = dxv;
        doodle_y = dyv;
        falling  = fall;
        frame    = 1'b1;
        tick();
        frame = 1'b0;
        while (busy && busy_len < 40) begin
            busy_len++;
            if (bounce) begin
                bounce_cnt++;
                bounce_at = busy_len;
            end
            frame = (busy_len == frame_again_at);
            if (busy_len == rst_at) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
        frame = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len, cnt, at;

        v_reset[0] = '{16'd240, 1'b1, 16'd192};
        v_reset[1] = '{16'd241, 1'b0, 16'd192};
        v_reset[2] = '{16'd360, 1'b1, 16'd64};
        v_reset[3] = '{16'd120, 1'b1, 16'd320};
        v_reset[4] = '{16'd0,   1'b1, 16'd448};

        v_s10[0] = '{16'd370, 1'b1, 16'd64};
        v_s10[1] = '{16'd250, 1'b1, 16'd192};
        v_s10[2] = '{16'd130, 1'b1, 16'd320};
        v_s10[3] = '{16'd10,  1'b1, 16'd448};
        v_s10[4] = '{16'd360, 1'b0, 16'd448};

        v_resp[0] = '{16'd10,  1'b1, 16'h00E1};
        v_resp[1] = '{16'd370, 1'b1, 16'd192};

        v_final[0] = '{16'd0,   1'b1, 16'h01C3};
        v_final[1] = '{16'd120, 1'b1, 16'h00E1};
        v_final[2] = '{16'd360, 1'b1, 16'd320};
        v_final[3] = '{16'd240, 1'b1, 16'd448};
        v_final[4] = '{16'd480, 1'b0, 16'd448};

        rst_n = 1'b0; frame = 1'b0; line = 1'b0; sy = '0;
        scroll = '0; doodle_x = '0; doodle_y = '0; falling = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset start", 32'(plate_start), 32'd0);
        check("reset platex", 32'(platex), 32'd0);
        check("reset bounce", 32'(bounce), 32'd0);

        for (int i = 0; i < 5; i++) line_query(v_reset[i], $sformatf("reset_line%0d", i));

        run_frame(6'd10, 16'd600, 16'd0, 1'b1, -1, -1, len, cnt, at);
        check("scroll10 busy_len", 32'(len), 32'd9);
        check("scroll10 bounce_cnt", 32'(cnt), 32'd0);
        for (int i = 0; i < 5; i++) line_query(v_s10[i], $sformatf("s10_line%0d", i));

        // Bring slot 0 to y=470, then a scroll of 20 wraps it to y=10.
        run_frame(6'd50, 16'd600, 16'd0, 1'b0, -1, -1, len, cnt, at);
        run_frame(6'd50, 16'd600, 16'd0, 1'b0, -1, -1, len, cnt, at);
        run_frame(6'd20, 16'd600, 16'd0, 1'b0, -1, -1, len, cnt, at);
        for (int i = 0; i < 2; i++) line_query(v_resp[i], $sformatf("resp_line%0d", i));

        // Slot 1 wraps next and must take the once-stepped LFSR value 0x1C3.
        run_frame(6'd60, 16'd600, 16'd0, 1'b0, -1, -1, len, cnt, at);
        run_frame(6'd50, 16'd600, 16'd0, 1'b0, -1, -1, len, cnt, at);
        for (int i = 0; i < 5; i++) line_query(v_final[i], $sformatf("final_line%0d", i));

        run_frame(6'd0, 16'd300, 16'd296, 1'b1, -1, -1, len, cnt, at);
        check("hit busy_len", 32'(len), 32'd9);
        check("hit bounce_cnt", 32'(cnt), 32'd1);
        check("hit bounce_at", 32'(at), 32'd9);

        run_frame(6'd0, 16'd300, 16'd296, 1'b0, -1, -1, len, cnt, at);
        check("rising busy_len", 32'(len), 32'd9);
        check("rising bounce_cnt", 32'(cnt), 32'd0);

        run_frame(6'd0, 16'd300, 16'd296, 1'b1, 3, -1, len, cnt, at);
        check("reframe busy_len", 32'(len), 32'd9);
        check("reframe bounce_cnt", 32'(cnt), 32'd1);
        check("reframe bounce_at", 32'(at), 32'd9);
        tick();
        check("reframe idle after", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) line_query(v_final[i], $sformatf("zero_scroll_line%0d", i));

        run_frame(6'd0, 16'd300, 16'd296, 1'b1, -1, 6, len, cnt, at);
        check("collide_rst busy_len", 32'(len), 32'd6);
        check("collide_rst bounce_cnt", 32'(cnt), 32'd0);
        check("collide_rst busy", 32'(busy), 32'd0);
        check("collide_rst bounce", 32'(bounce), 32'd0);
        check("collide_rst platex", 32'(platex), 32'd0);
        for (int i = 0; i < 5; i++) line_query(v_reset[i], $sformatf("post_rst_line%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plate_scheduler.md
PLATE_SCHEDULER -- requirements
Module: plate_scheduler

Interface
REQ-001 Parameter N_PLATES, 4, number of platform slots.
REQ-002 Parameter PLATE_W, 64, and PLATE_H, 8, platform sprite size in pixels.
REQ-003 Parameter DOODLE_W, 64, and DOODLE_H, 64, doodle sprite size in pixels.
REQ-004 Parameter V_RES, 480, and SPACING, 120, where N_PLATES*SPACING SHALL equal V_RES.
REQ-005 Parameter LFSR_SEED, 16'hACE1, nonzero LFSR reset value.
REQ-006 i_clk_25  in  1  pixel clock; all logic on its rising edge.
REQ-007 i_rst_n  in  1  reset, synchronous, active-low.
REQ-008 i_frame  in  1  one-cycle pulse, start of frame (blanking).
REQ-009 i_line  in  1  one-cycle pulse, start of scanline.
REQ-010 i_sy  in  16 signed  current scanline.
REQ-011 i_scroll  in  6  downward scroll this frame, pixels.
REQ-012 i_doodle_x, i_doodle_y  in  16 signed each  doodle top-left.
REQ-013 i_doodle_falling  in  1  doodle vertical motion is downward.
REQ-014 o_plate_start  out  1  one-cycle start pulse to the shared plate sprite engine.
REQ-015 o_platex  out  16 signed  x of the platform being drawn; held between pulses.
REQ-016 o_bounce  out  1  one-cycle pulse, doodle landed on a platform.
REQ-017 o_busy  out  1  frame update sequence active.

Function
REQ-018 Slot i SHALL hold signed 16-bit x[i], y[i]; reset x[i]=64+128*i, y[i]=V_RES-SPACING*(i+1) (defaults 64/192/320/448, 360/240/120/0).
REQ-019 FSM states IDLE, UPDATE, COLLIDE, DONE; slot index k cleared on entering UPDATE and COLLIDE.
REQ-020 IDLE: i_frame moves to UPDATE and samples i_scroll, i_doodle_x, i_doodle_y, i_doodle_falling into registers; i_frame in any other state SHALL be ignored.
REQ-021 UPDATE: one slot per cycle, k=0..N_PLATES-1; then COLLIDE.
REQ-022 UPDATE slot k: yn=y[k]+scroll; if yn>=V_RES then y[k]=yn-V_RES, x[k]={7'b0,lfsr[8:0]}, LFSR steps once; else y[k]=yn, x[k] unchanged.
REQ-023 Scroll 0 SHALL leave all slots and the LFSR unchanged.
REQ-024 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0; steps only on respawn.
REQ-025 COLLIDE: one slot per cycle using post-UPDATE values; hit when falling AND y[k]<=dy+DOODLE_H<y[k]+PLATE_H AND dx+DOODLE_W>x[k] AND dx<x[k]+PLATE_W; hits OR into a sticky flag.
REQ-026 After slot N_PLATES-1 in COLLIDE, move to DONE; DONE lasts one cycle, then IDLE.
REQ-027 o_bounce SHALL be high exactly during DONE when the flag is set; at most one pulse per frame; flag cleared on entering UPDATE.
REQ-028 o_busy SHALL be high in UPDATE, COLLIDE, DONE: 2*N_PLATES+1 cycles, starting the cycle after i_frame.
REQ-029 Line arbitration (all states): on i_line, lowest-index slot with y[i]==i_sy wins; next cycle o_plate_start=1 for one cycle and o_platex=x[winner].
REQ-030 No match on i_line: no pulse, o_platex unchanged.
REQ-031 i_line coinciding with a slot write SHALL compare against pre-write register values.
REQ-032 All comparisons SHALL be signed, 17-bit intermediate, no overflow wrap.

Reset
REQ-033 i_rst_n low at a clock edge SHALL force IDLE, slots per REQ-018, LFSR=LFSR_SEED, flag clear, o_plate_start=0, o_platex=0, o_bounce=0, o_busy=0, including mid-sequence; pending i_line dropped.

Verification
REQ-034 Reset, i_line with i_sy=240 -> o_plate_start one cycle later, o_platex=192; i_sy=241 -> no pulse.
REQ-035 i_frame, scroll=10, no doodle contact -> o_busy high 9 cycles; y=370/250/130/10; x unchanged; o_bounce never high.
REQ-036 Slot 0 at y=470, scroll=20 -> y[0]=10, x[0]=LFSR_SEED[8:0]=0x0E1, LFSR stepped once.
REQ-037 Scroll 0, doodle (300,296) falling -> slot 2 hit; o_bounce one cycle at DONE (9th busy cycle); same with falling=0 -> no pulse.
REQ-038 Second i_frame during busy -> ignored, sequence length unchanged; i_rst_n low in COLLIDE -> next cycle o_busy=0, slots at reset values, no o_bounce.
